rf_wb_arb: RTL and testbench
============================

RF_WB_ARB -- requirements
Module: rf_wb_arb

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  DW, 16, register data width
  AW, 4, register address width
  PC_REG, 15, register index holding the program counter
  STARVE_MAX, 4, maximum wait cycles for a general requester before it beats PC
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  clk  in  1  single clock, all state on rising edge
  rst_n  in  1  reset, asynchronous assert, active-low
  alu_valid / alu_ready  in / out  1 / 1  ALU writeback handshake
  alu_addr / alu_data  in  AW / DW  ALU destination and value
  ld_valid / ld_ready  in / out  1 / 1  load-unit writeback handshake
  ld_addr / ld_data  in  AW / DW  load destination and value
  pc_valid / pc_ready  in / out  1 / 1  PC-update handshake
  pc_wdata  in  DW  new PC value
  rsv_en / rsv_addr  in  1 / AW  issue-stage reservation of a destination register
  w_en / w_addr / w_data  out  1 / AW / DW  register-file general write port
  pc_en / pc_addr / pc_data  out  1 / AW / DW  register-file PC write port
  busy  out  2**AW  scoreboard, bit i set = write to register i pending

Function
REQ-003 A transfer SHALL occur on a requester when valid and ready are both high at a rising clk edge.
REQ-004 At most one ready SHALL be high per cycle; ready SHALL be combinational from valid inputs and internal state, and high only if the matching valid is high.
REQ-005 Grant priority SHALL be PC over ALU/LD, except when starve_cnt equals STARVE_MAX and alu_valid or ld_valid is high; then a general requester wins.
REQ-006 Between ALU and LD, the block SHALL round-robin via a 1-bit pointer: the one not granted last wins a tie; the pointer updates only on an ALU or LD transfer.
REQ-007 starve_cnt (3 bits) SHALL increment, saturating at STARVE_MAX, each cycle alu_valid or ld_valid is high and neither transfers; it SHALL clear on any ALU/LD transfer or when both are low.
REQ-008 The register-file outputs SHALL be registered: a transfer in cycle N drives the port in cycle N+1 for exactly one cycle.
REQ-009 ALU/LD transfer SHALL drive w_en=1, w_addr/w_data from the winner, pc_en=0; PC transfer SHALL drive pc_en=1, pc_addr=PC_REG, pc_data=pc_wdata, w_en=0.
REQ-010 w_en and pc_en SHALL never be high in the same cycle.
REQ-011 An ALU/LD write with addr==PC_REG SHALL go through the w port unchanged.
REQ-012 With no transfer, w_en=pc_en=0 and addr/data outputs SHALL hold their previous values.
REQ-013 busy[rsv_addr] SHALL set at the edge where rsv_en=1.
REQ-014 busy[a] SHALL clear at the edge where an ALU/LD transfer targets a; busy[PC_REG] SHALL also clear on a PC transfer.
REQ-015 If a set and a clear hit the same bit on the same edge, set SHALL win.
REQ-016 Clearing an already-clear busy bit SHALL be harmless; reservations SHALL not gate grants.

Reset
REQ-017 While rst_n=0 (asynchronous): w_en=pc_en=0, w_addr=w_data=pc_data=0, pc_addr=PC_REG, busy=0, starve_cnt=0, rr pointer selects ALU next.
REQ-018 All ready outputs SHALL be 0 while rst_n=0.
REQ-019 A transfer in progress when rst_n falls SHALL be dropped, with no rf write after reset release.
REQ-020 The first edge after rst_n rises SHALL operate normally.

Verification
REQ-021 alu_valid, addr=3, data=0x1234, alone -> alu_ready=1 same cycle; next cycle w_en=1, w_addr=3, w_data=0x1234, pc_en=0.
REQ-022 alu_valid and ld_valid held continuously after reset -> grants ALU, LD, ALU, LD on successive cycles; w_en high every cycle.
REQ-023 pc_valid, alu_valid held for 6 cycles -> PC granted for 4 cycles, then ALU in cycle 5, then PC; pc_en and w_en never both 1.
REQ-024 rsv_en addr=5, later ALU write to 5 -> busy[5]=1 until the ALU transfer edge, then 0; rsv_en addr=5 on that same edge -> busy[5] stays 1.
REQ-025 rst_n pulsed low mid-cycle during ld transfer -> w_en=0 immediately, busy=0, no write after release; next ld_valid grants normally.
REQ-026 pc_valid, pc_wdata=0x00FE -> next cycle pc_en=1, pc_addr=15, pc_data=0x00FE; busy[15] clears if set.

Source files
------------

// File: rtl/rf_wb_arb.sv
// rtl/rf_wb_arb.sv - register-file writeback arbiter for ALU, load unit and PC update
// PC normally has priority; a starved general requester eventually wins, ALU/LD share by round-robin.
module rf_wb_arb #(
  parameter int DW         = 16,
  parameter int AW         = 4,
  parameter int PC_REG     = 15,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [AW-1:0]     alu_addr,
  input  logic [DW-1:0]     alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DW-1:0]     ld_data,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic [DW-1:0]     pc_wdata,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  output logic              w_en,
  output logic [AW-1:0]     w_addr,
  output logic [DW-1:0]     w_data,
  output logic              pc_en,
  output logic [AW-1:0]     pc_addr,
  output logic [DW-1:0]     pc_data,
  output logic [2**AW-1:0]  busy
);

  localparam int NR = 2**AW;

  logic [2:0]    starve_cnt;
  logic [2:0]    starve_nxt;
  logic          rr_ld;        // 1: load unit wins the next ALU/LD tie
  logic          gen_valid;
  logic          starved;
  logic          gen_win;
  logic          pick_ld;
  logic          gen_xfer;
  logic          pc_xfer;
  logic [AW-1:0] gen_addr;
  logic [DW-1:0] gen_data;
  logic [NR-1:0] busy_nxt;

  always_comb begin
    gen_valid = alu_valid | ld_valid;
    starved   = (starve_cnt == 3'(STARVE_MAX));
    gen_win   = gen_valid & (~pc_valid | starved);
    pick_ld   = ld_valid & (~alu_valid | rr_ld);

    // Readies are forced low during reset so nothing can handshake.
    alu_ready = rst_n & gen_win & ~pick_ld;
    ld_ready  = rst_n & gen_win & pick_ld;
    pc_ready  = rst_n & pc_valid & ~gen_win;

    gen_xfer  = alu_ready | ld_ready;
    pc_xfer   = pc_ready;
    gen_addr  = pick_ld ? ld_addr : alu_addr;
    gen_data  = pick_ld ? ld_data : alu_data;
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (gen_xfer || !gen_valid)
      starve_nxt = 3'd0;
    else if (!starved)
      starve_nxt = starve_cnt + 3'd1;
  end

  // Reservation is applied last so a same-edge set beats any clear.
  always_comb begin
    busy_nxt = busy;
    if (gen_xfer)
      busy_nxt[gen_addr] = 1'b0;
    if (pc_xfer)
      busy_nxt[PC_REG] = 1'b0;
    if (rsv_en)
      busy_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_en       <= 1'b0;
      w_addr     <= '0;
      w_data     <= '0;
      pc_en      <= 1'b0;
      pc_addr    <= AW'(PC_REG);
      pc_data    <= '0;
      busy       <= '0;
      starve_cnt <= 3'd0;
      rr_ld      <= 1'b0;
    end else begin
      w_en       <= gen_xfer;
      pc_en      <= pc_xfer;
      starve_cnt <= starve_nxt;
      busy       <= busy_nxt;
      if (gen_xfer) begin
        w_addr <= gen_addr;
        w_data <= gen_data;
        rr_ld  <= ~pick_ld;
      end
      if (pc_xfer) begin
        pc_addr <= AW'(PC_REG);
        pc_data <= pc_wdata;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arb.sv
// tb/tb_rf_wb_arb.sv - scoreboard bench for rf_wb_arb against a behavioural arbitration model
module tb_rf_wb_arb;
  localparam int STARVE_MAX = 4;
  localparam int PC_REG     = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, ld_valid, pc_valid, rsv_en;
  logic        alu_ready, ld_ready, pc_ready;
  logic [3:0]  alu_addr, ld_addr, rsv_addr;
  logic [15:0] alu_data, ld_data, pc_wdata;
  logic        w_en, pc_en;
  logic [3:0]  w_addr, pc_addr;
  logic [15:0] w_data, pc_data, busy;

  rf_wb_arb dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .pc_valid(pc_valid), .pc_ready(pc_ready), .pc_wdata(pc_wdata),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .pc_en(pc_en), .pc_addr(pc_addr), .pc_data(pc_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w_en;
    logic [3:0]  w_addr;
    logic [15:0] w_data;
    logic        pc_en;
    logic [15:0] pc_data;
    logic [15:0] busy;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Behavioural model state: who was served last, how long general requesters waited.
  logic [15:0] m_busy;
  int          m_wait;
  bit          m_last_ld;
  logic [3:0]  m_w_addr;
  logic [15:0] m_w_data;
  logic [15:0] m_pc_data;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = '0; m_wait = 0; m_last_ld = 1'b1;
    m_w_addr = '0; m_w_data = '0; m_pc_data = '0;
  endtask

  // 0 none, 1 ALU, 2 LD, 3 PC
  function automatic int winner(bit av, bit lv, bit pv);
    if ((av || lv) && (!pv || m_wait >= STARVE_MAX)) begin
      if (av && lv) return m_last_ld ? 1 : 2;
      return av ? 1 : 2;
    end
    return pv ? 3 : 0;
  endfunction

  task automatic model_cycle(input int win, input bit gen_req,
                             input logic [3:0] aa, input logic [15:0] ad,
                             input logic [3:0] la, input logic [15:0] ldd,
                             input logic [15:0] pd, input bit re, input logic [3:0] ra,
                             output exp_t e);
    e.w_en  = (win == 1 || win == 2);
    e.pc_en = (win == 3);
    if (win == 1) begin m_w_addr = aa; m_w_data = ad;  m_last_ld = 1'b0; m_busy[aa] = 1'b0; end
    if (win == 2) begin m_w_addr = la; m_w_data = ldd; m_last_ld = 1'b1; m_busy[la] = 1'b0; end
    if (win == 3) begin m_pc_data = pd; m_busy[PC_REG] = 1'b0; end
    if (re) m_busy[ra] = 1'b1;
    if (e.w_en || !gen_req) m_wait = 0;
    else if (m_wait < STARVE_MAX) m_wait++;
    e.w_addr = m_w_addr; e.w_data = m_w_data; e.pc_data = m_pc_data; e.busy = m_busy;
  endtask

  task automatic step(input bit av, input logic [3:0] aa, input logic [15:0] ad,
                      input bit lv, input logic [3:0] la, input logic [15:0] ldd,
                      input bit pv, input logic [15:0] pd,
                      input bit re, input logic [3:0] ra);
    int   win;
    exp_t e;
    @(negedge clk);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    ld_valid  = lv; ld_addr  = la; ld_data  = ldd;
    pc_valid  = pv; pc_wdata = pd;
    rsv_en    = re; rsv_addr = ra;
    #1;
    win = winner(av, lv, pv);
    check("ready", {alu_ready, ld_ready, pc_ready}, {win == 1, win == 2, win == 3});
    model_cycle(win, av || lv, aa, ad, la, ldd, pd, re, ra, e);
    q.push_back(e);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_pulse();
    exp_t e;
    @(negedge clk);
    alu_valid = 0; pc_valid = 0; rsv_en = 0;
    ld_valid = 1; ld_addr = 4'h9; ld_data = 16'hBEEF;
    #1 check("ld_ready_before_reset", ld_ready, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_outputs", {w_en, pc_en, w_addr, w_data, pc_addr, pc_data}, {2'b00, 4'h0, 16'h0, 4'hF, 16'h0});
    check("rst_busy", busy, 16'h0);
    check("rst_ready", {alu_ready, ld_ready, pc_ready}, 3'b000);
    ld_valid = 0;
    #1 rst_n = 1'b1;
    q.delete();
    model_reset();
    model_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, e);
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("w_port", {w_en, w_addr, w_data}, {e.w_en, e.w_addr, e.w_data});
        check("pc_port", {pc_en, pc_addr, pc_data}, {e.pc_en, 4'(PC_REG), e.pc_data});
        check("busy", busy, e.busy);
        check("exclusive_en", w_en & pc_en, 0);
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0;
    alu_valid = 1; ld_valid = 1; pc_valid = 1; rsv_en = 1;
    alu_addr = 4'h1; ld_addr = 4'h2; rsv_addr = 4'h3;
    alu_data = 16'h1; ld_data = 16'h2; pc_wdata = 16'h3;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("init_outputs", {w_en, pc_en, w_addr, w_data, pc_addr, pc_data}, {2'b00, 4'h0, 16'h0, 4'hF, 16'h0});
    check("init_busy", busy, 16'h0);
    check("init_ready", {alu_ready, ld_ready, pc_ready}, 3'b000);
    alu_valid = 0; ld_valid = 0; pc_valid = 0; rsv_en = 0;
    @(negedge clk);
    rst_n = 1'b1;

    step(1, 4'd3, 16'h1234, 0, 0, 0, 0, 0, 0, 0);
    idle();
    for (int i = 0; i < 6; i++)
      step(1, 4'(i), 16'(16'hA000 + i), 1, 4'(i + 8), 16'(16'hB000 + i), 0, 0, 0, 0);
    idle();
    for (int i = 0; i < 7; i++)
      step(1, 4'd7, 16'(16'hC000 + i), 0, 0, 0, 1, 16'(16'h0100 + i), 0, 0);
    idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd5);
    idle();
    step(1, 4'd5, 16'h5555, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd5);
    step(1, 4'd5, 16'h6666, 0, 0, 0, 0, 0, 1, 4'd5);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd15);
    step(0, 0, 0, 0, 0, 0, 1, 16'h00FE, 0, 0);
    step(1, 4'd15, 16'h7777, 0, 0, 0, 0, 0, 1, 4'd2);
    reset_pulse();
    step(0, 0, 0, 1, 4'd6, 16'h0D0D, 0, 0, 0, 0);
    idle();

    for (int i = 0; i < 1500; i++) begin
      if (i % 500 == 499) reset_pulse();
      step(($urandom % 3) == 0, 4'($urandom), 16'($urandom),
           ($urandom % 3) == 0, 4'($urandom), 16'($urandom),
           ($urandom % 4) != 0, 16'($urandom),
           ($urandom % 3) == 0, 4'($urandom));
    end
    idle();
    repeat (2) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
